// File: rtl/exc_commit_ctrl_pkg.sv
// exc_commit_ctrl_pkg: exception flag indices, ExcCodes and shared types for the WB commit controller
package exc_commit_ctrl_pkg;
    localparam int EXF_ADEL_IF  = 0;
    localparam int EXF_RI       = 1;
    localparam int EXF_OV       = 2;
    localparam int EXF_SYS      = 3;
    localparam int EXF_BP       = 4;
    localparam int EXF_ADEL_MEM = 5;
    localparam int EXF_ADES     = 6;
    localparam logic [4:0] EX_INT  = 5'd0;
    localparam logic [4:0] EX_ADEL = 5'd4;
    localparam logic [4:0] EX_ADES = 5'd5;
    localparam logic [4:0] EX_SYS  = 5'd8;
    localparam logic [4:0] EX_BP   = 5'd9;
    localparam logic [4:0] EX_RI   = 5'd10;
    localparam logic [4:0] EX_OV   = 5'd12;
    typedef enum logic {IDLE, REDIR} state_t;
    typedef struct packed {
        logic       any;
        logic [4:0] excode;
        logic       is_fetch_adel;
    } exc_sel_t;
endpackage

// File: rtl/exc_commit_ctrl_prio_enc.sv
// exc_prio_enc: picks the winning exception (interrupt first, then faults by flag priority)
module exc_prio_enc
    import exc_commit_ctrl_pkg::*;
#(
    parameter int NFLAG = 7
) (
    input  logic [NFLAG-1:0] ws_ex_flags,
    input  logic             has_int,
    output exc_sel_t         sel
);
    // Flag bit order already matches fault priority, so the lowest set bit wins after INT
    always_comb begin
        sel.any           = has_int | (|ws_ex_flags);
        sel.is_fetch_adel = ~has_int & ws_ex_flags[EXF_ADEL_IF];
        sel.excode        = has_int                    ? EX_INT  :
                            ws_ex_flags[EXF_ADEL_IF]   ? EX_ADEL :
                            ws_ex_flags[EXF_RI]        ? EX_RI   :
                            ws_ex_flags[EXF_OV]        ? EX_OV   :
                            ws_ex_flags[EXF_SYS]       ? EX_SYS  :
                            ws_ex_flags[EXF_BP]        ? EX_BP   :
                            ws_ex_flags[EXF_ADEL_MEM]  ? EX_ADEL :
                            ws_ex_flags[EXF_ADES]      ? EX_ADES : EX_INT;
    end
endmodule

// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: WB-stage exception/ERET commit, pipeline flush and held fetch redirect
module exc_commit_ctrl
    import exc_commit_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = 32'hbfc00380,
    parameter int          NFLAG   = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ws_valid,
    input  logic [31:0]      ws_pc,
    input  logic             ws_bd,
    input  logic [NFLAG-1:0] ws_ex_flags,
    input  logic [31:0]      ws_badvaddr,
    input  logic             ws_eret,
    input  logic             has_int,
    input  logic [31:0]      c0_epc,
    input  logic             redirect_ready,
    output logic             wb_ex,
    output logic [4:0]       wb_excode,
    output logic             wb_bd,
    output logic [31:0]      wb_pc,
    output logic [31:0]      wb_badvaddr,
    output logic             eret_flush,
    output logic             ws_commit,
    output logic             flush_pipe,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [31:0]      exc_count
);
    state_t      state_q, state_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] exc_count_q, exc_count_d;
    exc_sel_t    sel;
    logic        idle, take;

    exc_prio_enc #(.NFLAG(NFLAG)) u_enc (
        .ws_ex_flags (ws_ex_flags),
        .has_int     (has_int),
        .sel         (sel)
    );

    // Commit decisions are only made from IDLE and are silenced during reset
    always_comb begin
        idle          = (state_q == IDLE) & ~reset;
        take          = idle & ws_valid & (sel.any | ws_eret);
        wb_ex         = take & sel.any;
        eret_flush    = take & ~sel.any;
        ws_commit     = idle & ws_valid & ~take;
        flush_pipe    = take | ((state_q == REDIR) & ~reset);
        wb_excode     = sel.excode;
        wb_bd         = ws_bd;
        wb_pc         = ws_pc;
        wb_badvaddr   = sel.is_fetch_adel ? ws_pc : ws_badvaddr;
        state_d       = take ? REDIR : (state_q == REDIR) & redirect_ready ? IDLE : state_q;
        redirect_pc_d = take ? (sel.any ? EXC_VEC : c0_epc) : redirect_pc_q;
        exc_count_d   = take & ~(&exc_count_q) ? exc_count_q + 32'd1 : exc_count_q;
    end

    // FSM state, held redirect target and saturating commit counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            redirect_pc_q <= '0;
            exc_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            exc_count_q   <= exc_count_d;
        end
    end

    assign redirect_valid = state_q == REDIR;
    assign redirect_pc    = redirect_pc_q;
    assign exc_count      = exc_count_q;
endmodule
